// File: rtl/calc_rr_sched.sv
// Round-robin front end that shares one registered add/sub datapath
// between NREQ requesters, one transaction in flight at a time.
module calc_rr_sched #(
    parameter int WD   = 8,
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*WD-1:0] req_i0,
    input  logic [NREQ*WD-1:0] req_i1,
    input  logic [NREQ-1:0]    req_sub,
    output logic               calc_go,
    output logic [WD-1:0]      calc_i0,
    output logic [WD-1:0]      calc_i1,
    output logic               calc_sub,
    input  logic [WD-1:0]      calc_o,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [WD-1:0]      rsp_data
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt;
    logic           gnt_any;
    logic           take;
    logic [CW-1:0]  cnt;
    logic [WD-1:0]  op0;
    logic [WD-1:0]  op1;
    logic           op_sub;
    logic [IDW-1:0] id_q;
    logic [WD-1:0]  res_q;

    function automatic logic [IDW-1:0] wrap_add(
        input logic [IDW-1:0] base,
        input int             off
    );
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Scan from the far end so the nearest valid index after rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_add(rr_ptr, i)]) begin
                gnt_any = 1'b1;
                gnt     = wrap_add(rr_ptr, i);
            end
        end
    end

    assign take = (state == IDLE) && gnt_any && !rst;

    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt_any) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            op0    <= '0;
            op1    <= '0;
            op_sub <= 1'b0;
            id_q   <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                op0    <= req_i0[gnt*WD +: WD];
                op1    <= req_i1[gnt*WD +: WD];
                op_sub <= req_sub[gnt];
                id_q   <= gnt;
                rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            end
            if (state == ISSUE) begin
                cnt <= CW'(LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == WAIT && cnt == '0) begin
                res_q <= calc_o;
            end
        end
    end

    assign calc_go   = (state == ISSUE);
    assign calc_i0   = op0;
    assign calc_i1   = op1;
    assign calc_sub  = op_sub;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = res_q;

endmodule

// File: tb/tb_calc_rr_sched.sv
// Scoreboard bench for calc_rr_sched: u1 runs LAT=1, u3 runs LAT=3,
// each against its own behavioural datapath.
module tb_calc_rr_sched;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         vcyc;
    } exp_t;

    logic clk;
    int   cyc   = 0;
    int   nchk  = 0;
    int   nfail = 0;

    exp_t q1[$];
    exp_t q3[$];

    logic        rst1, rst3;
    logic [3:0]  req_valid1, req_valid3;
    logic [3:0]  req_ready1, req_ready3;
    logic [31:0] req_i0_1, req_i1_1, req_i0_3, req_i1_3;
    logic [3:0]  req_sub1, req_sub3;
    logic        go1, go3, csub1, csub3;
    logic [7:0]  ci0_1, ci1_1, ci0_3, ci1_3;
    logic [7:0]  co1, co3;
    logic        rv1, rv3, rr1, rr3;
    logic [1:0]  rid1, rid3;
    logic [7:0]  rdata1, rdata3;
    logic        pv1 = 1'b0;
    logic        pv3 = 1'b0;
    logic [7:0]  p3 [3];

    logic [7:0] rr_a [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] rr_b [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
    logic [7:0] rr_e [4] = '{8'h10, 8'h1F, 8'h32, 8'h3D};

    calc_rr_sched #(.WD(8), .NREQ(4), .LAT(1)) u1 (
        .clk(clk), .rst(rst1),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_i0(req_i0_1), .req_i1(req_i1_1), .req_sub(req_sub1),
        .calc_go(go1), .calc_i0(ci0_1), .calc_i1(ci1_1),
        .calc_sub(csub1), .calc_o(co1),
        .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_id(rid1), .rsp_data(rdata1)
    );

    calc_rr_sched #(.WD(8), .NREQ(4), .LAT(3)) u3 (
        .clk(clk), .rst(rst3),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_i0(req_i0_3), .req_i1(req_i1_3), .req_sub(req_sub3),
        .calc_go(go3), .calc_i0(ci0_3), .calc_i1(ci1_3),
        .calc_sub(csub3), .calc_o(co3),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_id(rid3), .rsp_data(rdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath models emit 0x5A except exactly LAT cycles after calc_go.
    always @(posedge clk) begin
        co1 <= go1 ? (csub1 ? ci0_1 - ci1_1 : ci0_1 + ci1_1) : 8'h5A;
    end

    always @(posedge clk) begin
        p3[0] <= go3 ? (csub3 ? ci0_3 - ci1_3 : ci0_3 + ci1_3) : 8'h5A;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign co3 = p3[2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst1) begin
            if (rv1 && !pv1) begin
                if (q1.size() == 0) chk("u1_unexpected_rsp", 32'(1), 32'(0));
                else chk("u1_rsp_cycle", 32'(cyc), 32'(q1[0].vcyc));
            end
            if (rv1 && rr1 && q1.size() != 0) begin
                chk("u1_rsp_id", 32'(rid1), 32'(q1[0].id));
                chk("u1_rsp_data", 32'(rdata1), 32'(q1[0].data));
                void'(q1.pop_front());
            end
        end
        pv1 <= rv1 && !rr1;
    end

    always @(negedge clk) begin
        if (!rst3) begin
            if (rv3 && !pv3) begin
                if (q3.size() == 0) chk("u3_unexpected_rsp", 32'(1), 32'(0));
                else chk("u3_rsp_cycle", 32'(cyc), 32'(q3[0].vcyc));
            end
            if (rv3 && rr3 && q3.size() != 0) begin
                chk("u3_rsp_id", 32'(rid3), 32'(q3[0].id));
                chk("u3_rsp_data", 32'(rdata3), 32'(q3[0].data));
                void'(q3.pop_front());
            end
        end
        pv3 <= rv3 && !rr3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int inst, input int k, input logic [7:0] a,
                          input logic [7:0] b, input logic s);
        if (inst == 1) begin
            req_i0_1[k*8 +: 8] = a;
            req_i1_1[k*8 +: 8] = b;
            req_sub1[k]        = s;
        end else begin
            req_i0_3[k*8 +: 8] = a;
            req_i1_3[k*8 +: 8] = b;
            req_sub3[k]        = s;
        end
    endtask

    task automatic wait_grant(input int inst, input int id, output int t);
        logic [3:0] rdy;
        logic [3:0] want;
        rdy  = '0;
        want = 4'b0001 << id;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = (inst == 1) ? req_ready1 : req_ready3;
            if (rdy != 4'b0000) break;
        end
        chk("grant", 32'(rdy), 32'(want));
        t = cyc;
    endtask

    task automatic drain(input int inst);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n = (inst == 1) ? q1.size() : q3.size();
            if (n == 0) break;
        end
        chk("drain", 32'(n), 32'(0));
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int v;
        rst1 = 1'b1; rst3 = 1'b1;
        req_valid1 = '0; req_valid3 = '0;
        req_i0_1 = '0; req_i1_1 = '0; req_sub1 = '0;
        req_i0_3 = '0; req_i1_3 = '0; req_sub3 = '0;
        rr1 = 1'b1; rr3 = 1'b1;
        repeat (2) tick();
        rst1 = 1'b0; rst3 = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready1), 32'(0));
        chk("rst_calc_go", 32'(go1), 32'(0));
        chk("rst_rsp_valid", 32'(rv1), 32'(0));
        chk("rst_rsp_id", 32'(rid1), 32'(0));
        chk("rst_rsp_data", 32'(rdata1), 32'(0));
        chk("rst_calc_i0", 32'(ci0_1), 32'(0));
        chk("rst_calc_sub", 32'(csub1), 32'(0));
        chk("rst_u3_valid", 32'(rv3), 32'(0));

        // single add from requester 0
        tick();
        set_op(1, 0, 8'h05, 8'h03, 1'b0);
        req_valid1 = 4'b0001;
        wait_grant(1, 0, t);
        q1.push_back('{id: 2'd0, data: 8'h08, vcyc: t + 3});
        tick();
        req_valid1 = '0;
        @(negedge clk);
        chk("add_calc_go", 32'(go1), 32'(1));
        chk("add_calc_i0", 32'(ci0_1), 32'(8'h05));
        chk("add_calc_i1", 32'(ci1_1), 32'(8'h03));
        drain(1);

        // subtract wrapping below zero
        set_op(1, 2, 8'h03, 8'h05, 1'b1);
        req_valid1 = 4'b0100;
        wait_grant(1, 2, t);
        q1.push_back('{id: 2'd2, data: 8'hFE, vcyc: t + 3});
        tick();
        req_valid1 = '0;
        drain(1);

        // response backpressure for five cycles
        rr1 = 1'b0;
        set_op(1, 1, 8'h7F, 8'h01, 1'b0);
        req_valid1 = 4'b0010;
        wait_grant(1, 1, t);
        q1.push_back('{id: 2'd1, data: 8'h80, vcyc: t + 3});
        tick();
        req_valid1 = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv1) break;
        end
        v = cyc;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rv1), 32'(1));
            chk("bp_data", 32'(rdata1), 32'(8'h80));
            chk("bp_id", 32'(rid1), 32'(1));
            chk("bp_req_ready", 32'(req_ready1), 32'(0));
            tick();
            if (i == 0) begin
                set_op(1, 3, 8'h40, 8'h01, 1'b1);
                req_valid1 = 4'b1000;
            end
            if (i < 4) @(negedge clk);
        end
        rr1 = 1'b1;
        @(negedge clk);
        chk("resp_no_grant", 32'(req_ready1), 32'(0));
        wait_grant(1, 3, t);
        chk("idle_after_hs", 32'(t), 32'(v + 6));
        q1.push_back('{id: 2'd3, data: 8'h3F, vcyc: t + 3});
        tick();
        req_valid1 = '0;
        drain(1);

        // round robin with all requesters held valid out of reset
        rst1 = 1'b1;
        for (int k = 0; k < 4; k++) set_op(1, k, rr_a[k], rr_b[k], k[0]);
        tick();
        rst1 = 1'b0;
        req_valid1 = 4'hF;
        v = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(1, k % 4, t);
            if (k > 0) chk("rr_spacing", 32'(t - v), 32'(4));
            v = t;
            q1.push_back('{id: 2'(k % 4), data: rr_e[k % 4], vcyc: t + 3});
        end
        tick();
        req_valid1 = '0;
        drain(1);

        // LAT=3: 0x80 + 0x80 wraps to zero
        set_op(3, 3, 8'h80, 8'h80, 1'b0);
        req_valid3 = 4'b1000;
        wait_grant(3, 3, t);
        q3.push_back('{id: 2'd3, data: 8'h00, vcyc: t + 5});
        tick();
        req_valid3 = '0;
        @(negedge clk);
        chk("lat3_go", 32'(go3), 32'(1));
        @(negedge clk);
        chk("lat3_go_once", 32'(go3), 32'(0));
        drain(3);

        // reset during WAIT abandons the transaction and the pointer
        set_op(3, 0, 8'h11, 8'h22, 1'b0);
        req_valid3 = 4'b0001;
        wait_grant(3, 0, t);
        tick();
        req_valid3 = '0;
        tick();
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rv3), 32'(0));
        end
        tick();
        set_op(3, 1, 8'h01, 8'h01, 1'b0);
        req_valid3 = 4'b0011;
        wait_grant(3, 0, t);
        q3.push_back('{id: 2'd0, data: 8'h33, vcyc: t + 5});
        tick();
        req_valid3 = '0;
        drain(3);

        repeat (3) tick();
        chk("sb1_empty", 32'(q1.size()), 32'(0));
        chk("sb3_empty", 32'(q3.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
